// File: rtl/writeback_stage.sv
// Final pipeline stage: registers the MEM/WB boundary, extracts sub-word loads and drives the register-file write port.
// Optional retired-instruction counter is built only when WB_RETIRE_CNT_EN is defined.
module writeback_stage #(
  parameter int RETIRE_CNT_WIDTH = 32,
  parameter int DWIDTH           = 32,
  parameter int AWIDTH           = 5
) (
  input  logic                        wb_clk,
  input  logic                        wb_rst,
  input  logic                        wb_i_ce,
  input  logic                        wb_i_stall,
  input  logic [DWIDTH-1:0]           wb_i_alu_result,
  input  logic [DWIDTH-1:0]           wb_i_mem_data,
  input  logic [AWIDTH-1:0]           wb_i_addr_rd,
  input  logic                        wb_i_reg_wr,
  input  logic                        wb_i_memtoreg,
  input  logic [1:0]                  wb_i_load_size,
  input  logic                        wb_i_load_unsigned,
  output logic [DWIDTH-1:0]           wb_o_data_rd,
  output logic [AWIDTH-1:0]           wb_o_addr_rd,
  output logic                        wb_o_reg_wr,
  output logic                        wb_o_ce,
  output logic [RETIRE_CNT_WIDTH-1:0] wb_o_retired
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [DWIDTH-1:0]   data_q, data_d;
  logic [AWIDTH-1:0]   addr_q, addr_d;
  logic                reg_wr_q, reg_wr_d;
  logic [15:0]         half_s;
  logic [7:0]          byte_s;
  logic [DWIDTH-1:0]   load_s;
  logic [DWIDTH-1:0]   wdata_s;

  // Big-endian sub-word extraction: lower offsets address the more significant lanes.
  always_comb begin
    half_s = wb_i_alu_result[1] ? wb_i_mem_data[15:0] : wb_i_mem_data[31:16];
    byte_s = 8'h00;
    case (wb_i_alu_result[1:0])
      2'b00:   byte_s = wb_i_mem_data[31:24];
      2'b01:   byte_s = wb_i_mem_data[23:16];
      2'b10:   byte_s = wb_i_mem_data[15:8];
      2'b11:   byte_s = wb_i_mem_data[7:0];
      default: byte_s = 8'h00;
    endcase
    load_s = wb_i_mem_data;
    case (wb_i_load_size)
      2'b01: begin
        if (wb_i_load_unsigned) load_s = {16'h0000, half_s};
        else                    load_s = {{16{half_s[15]}}, half_s};
      end
      2'b10: begin
        if (wb_i_load_unsigned) load_s = {24'h000000, byte_s};
        else                    load_s = {{24{byte_s[7]}}, byte_s};
      end
      default: load_s = wb_i_mem_data;
    endcase
    if (wb_i_memtoreg) wdata_s = load_s;
    else               wdata_s = wb_i_alu_result;
  end

  // Next-state: stall holds everything, ce captures, otherwise a bubble keeps data/addr.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    addr_d   = addr_q;
    reg_wr_d = reg_wr_q;
    if (wb_i_stall) begin
      state_d  = state_q;
    end else if (wb_i_ce) begin
      state_d  = FULL;
      data_d   = wdata_s;
      addr_d   = wb_i_addr_rd;
      reg_wr_d = wb_i_reg_wr && (wb_i_addr_rd != {AWIDTH{1'b0}});
    end else begin
      state_d  = EMPTY;
      reg_wr_d = 1'b0;
    end
  end

  // Stage registers with synchronous reset.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q  <= EMPTY;
      data_q   <= {DWIDTH{1'b0}};
      addr_q   <= {AWIDTH{1'b0}};
      reg_wr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      addr_q   <= addr_d;
      reg_wr_q <= reg_wr_d;
    end
  end

  assign wb_o_data_rd = data_q;
  assign wb_o_addr_rd = addr_q;
  assign wb_o_reg_wr  = reg_wr_q;
  assign wb_o_ce      = (state_q == FULL);

`ifdef WB_RETIRE_CNT_EN
  logic [RETIRE_CNT_WIDTH-1:0] retired_q, retired_d;
  logic                        retire_inc_s;

  // Retire count advances on every captured instruction, including rd = 0; wraps silently.
  always_comb begin
    retire_inc_s = !wb_i_stall && wb_i_ce;
    if (retire_inc_s) retired_d = retired_q + RETIRE_CNT_WIDTH'(1);
    else              retired_d = retired_q;
  end

  // Counter register.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) retired_q <= {RETIRE_CNT_WIDTH{1'b0}};
    else        retired_q <= retired_d;
  end

  assign wb_o_retired = retired_q;
`else
  assign wb_o_retired = {RETIRE_CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: per-cycle expectations are queued at drive time and popped after the edge.
module tb_writeback_stage;

  logic        wb_clk = 1'b0;
  logic        wb_rst, wb_i_ce, wb_i_stall, wb_i_reg_wr, wb_i_memtoreg, wb_i_load_unsigned;
  logic [31:0] wb_i_alu_result, wb_i_mem_data, wb_o_data_rd;
  logic [4:0]  wb_i_addr_rd, wb_o_addr_rd;
  logic [1:0]  wb_i_load_size;
  logic        wb_o_reg_wr, wb_o_ce;
  logic [3:0]  wb_o_retired;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  addr;
    logic        rw;
    logic        ce;
    logic [3:0]  cnt;
  } exp_t;

  exp_t m;
  exp_t exp_q[$];

  writeback_stage #(.RETIRE_CNT_WIDTH(4), .DWIDTH(32), .AWIDTH(5)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .wb_i_ce(wb_i_ce), .wb_i_stall(wb_i_stall),
    .wb_i_alu_result(wb_i_alu_result), .wb_i_mem_data(wb_i_mem_data),
    .wb_i_addr_rd(wb_i_addr_rd), .wb_i_reg_wr(wb_i_reg_wr), .wb_i_memtoreg(wb_i_memtoreg),
    .wb_i_load_size(wb_i_load_size), .wb_i_load_unsigned(wb_i_load_unsigned),
    .wb_o_data_rd(wb_o_data_rd), .wb_o_addr_rd(wb_o_addr_rd), .wb_o_reg_wr(wb_o_reg_wr),
    .wb_o_ce(wb_o_ce), .wb_o_retired(wb_o_retired)
  );

  always #5 wb_clk = ~wb_clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] mem, input logic [1:0] off,
                                             input logic [1:0] sz, input logic uns);
    logic [31:0] t;
    logic [15:0] h;
    logic [7:0]  b;
    if (sz == 2'b01) begin
      t = mem >> (16 * (1 - int'(off[1])));
      h = t[15:0];
      return uns ? {16'h0000, h} : {{16{h[15]}}, h};
    end else if (sz == 2'b10) begin
      t = mem >> (8 * (3 - int'(off)));
      b = t[7:0];
      return uns ? {24'h000000, b} : {{24{b[7]}}, b};
    end
    return mem;
  endfunction

  task automatic drive(input logic rst, input logic stall, input logic ce, input logic rw,
                       input logic m2r, input logic [1:0] sz, input logic uns,
                       input logic [31:0] alu, input logic [31:0] mem, input logic [4:0] rd);
    exp_t e;
    wb_rst = rst; wb_i_stall = stall; wb_i_ce = ce; wb_i_reg_wr = rw; wb_i_memtoreg = m2r;
    wb_i_load_size = sz; wb_i_load_unsigned = uns; wb_i_alu_result = alu;
    wb_i_mem_data = mem; wb_i_addr_rd = rd;
    if (rst) begin
      m = '{data: 32'h0, addr: 5'd0, rw: 1'b0, ce: 1'b0, cnt: 4'd0};
    end else if (stall) begin
      m = m;
    end else if (ce) begin
      m.data = m2r ? model_load(mem, alu[1:0], sz, uns) : alu;
      m.addr = rd;
      m.rw   = rw && (rd != 5'd0);
      m.ce   = 1'b1;
`ifdef WB_RETIRE_CNT_EN
      m.cnt  = m.cnt + 4'd1;
`endif
    end else begin
      m.rw = 1'b0;
      m.ce = 1'b0;
    end
    exp_q.push_back(m);
    @(posedge wb_clk);
    #1;
    if (exp_q.size() == 0) begin
      check_val("sb_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_val("data", wb_o_data_rd, e.data);
      check_val("addr", {27'd0, wb_o_addr_rd}, {27'd0, e.addr});
      check_val("reg_wr", {31'd0, wb_o_reg_wr}, {31'd0, e.rw});
      check_val("ce", {31'd0, wb_o_ce}, {31'd0, e.ce});
      check_val("retired", {28'd0, wb_o_retired}, {28'd0, e.cnt});
    end
  endtask

  initial begin
    logic [31:0] held;
    logic [3:0]  exp_wrap;
    wb_rst = 1'b1; wb_i_ce = 1'b1; wb_i_stall = 1'b0; wb_i_reg_wr = 1'b1; wb_i_memtoreg = 1'b0;
    wb_i_load_size = 2'b00; wb_i_load_unsigned = 1'b0; wb_i_alu_result = 32'h0;
    wb_i_mem_data = 32'h0; wb_i_addr_rd = 5'd0;
    m = '{data: 32'h0, addr: 5'd0, rw: 1'b0, ce: 1'b0, cnt: 4'd0};

    // Reset held two cycles with ce high
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'hDEAD_BEEF, 32'h0, 5'd7);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'hDEAD_BEEF, 32'h0, 5'd7);
    check_val("rst_data", wb_o_data_rd, 32'h0);
    check_val("rst_ce", {31'd0, wb_o_ce}, 32'd0);

    // ALU writeback, first cycle after reset
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h1234_5678, 32'h0, 5'd5);
    check_val("alu_data", wb_o_data_rd, 32'h1234_5678);
`ifdef WB_RETIRE_CNT_EN
    check_val("alu_retired", {28'd0, wb_o_retired}, 32'd1);
`else
    check_val("alu_retired", {28'd0, wb_o_retired}, 32'd0);
`endif

    // Sub-word loads
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_1001, 32'h80FF_7F01, 5'd3);
    check_val("lb_off1", wb_o_data_rd, 32'hFFFF_FFFF);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 32'h0000_1000, 32'h80FF_7F01, 5'd3);
    check_val("lhu_off0", wb_o_data_rd, 32'h0000_80FF);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 32'h0000_1002, 32'h80FF_7F01, 5'd3);
    check_val("lh_off2", wb_o_data_rd, 32'h0000_7F01);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_1000, 32'h80FF_7F01, 5'd3);
    check_val("lb_off0", wb_o_data_rd, 32'hFFFF_FF80);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 32'h0000_1003, 32'h80FF_7F01, 5'd3);
    check_val("lw_sz3", wb_o_data_rd, 32'h80FF_7F01);

    // Register 0 suppression
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'hAAAA_5555, 32'h0, 5'd0);
    check_val("r0_reg_wr", {31'd0, wb_o_reg_wr}, 32'd0);
    check_val("r0_ce", {31'd0, wb_o_ce}, 32'd1);

    // Capture, stall 3 cycles with changing inputs, then bubble
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'hCAFE_0001, 32'h0, 5'd9);
    held = wb_o_data_rd;
    for (int i = 0; i < 3; i++)
      drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, $urandom, $urandom, 5'(i + 20));
    check_val("stall_hold", wb_o_data_rd, 32'hCAFE_0001);
    // Between-edge reset glitch must not disturb state
    #1 wb_rst = 1'b1;
    #2 wb_rst = 1'b0;
    check_val("glitch_hold", wb_o_data_rd, held);
    check_val("glitch_ce", {31'd0, wb_o_ce}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h1111_1111, 32'h0, 5'd4);
    check_val("bubble_ce", {31'd0, wb_o_ce}, 32'd0);
    check_val("bubble_data", wb_o_data_rd, 32'hCAFE_0001);

    // Random mix of all controls
    for (int i = 0; i < 60; i++)
      drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0), 1'($urandom),
            1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom,
            5'($urandom_range(0, 3)));

    // Counter wrap: 17 retirements in a 4-bit counter
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0);
    for (int i = 0; i < 17; i++)
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'(i), 32'h0, 5'd1);
`ifdef WB_RETIRE_CNT_EN
    exp_wrap = 4'd1;
`else
    exp_wrap = 4'd0;
`endif
    check_val("wrap", {28'd0, wb_o_retired}, {28'd0, exp_wrap});

    // Reset while stalled clears everything
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h5, 32'h0, 5'd5);
    check_val("rst_stall_data", wb_o_data_rd, 32'h0);
    check_val("rst_stall_ret", {28'd0, wb_o_retired}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
